instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Front end feeding the control unit: owns the PC, fetches 32-bit instructions
//  from instruction memory over a req/gnt + rvalid handshake, holds the current
//  instruction and splits it into op/f3/f7 for the UC. Applies the UC's pcSrc
//  and the datapath branch/jump target to select the next PC on retire.
// PARAMETERS
//  XLEN      32            data/instruction width (fixed 32, RV32)
//  RESET_PC  32'h0000_0000 PC value loaded by reset
// PORTS
//  clk         in   1   single clock, all state on posedge
//  reset       in   1   synchronous, active-high
//  imemReq     out  1   fetch request valid
//  imemAddr    out  32  fetch address, stable while imemReq && !imemGnt
//  imemGnt     in   1   request accepted this cycle
//  imemRValid  in   1   read data valid (>=1 cycle after gnt)
//  imemRData   in   32  read data
//  instrValid  out  1   instr/op/f3/f7/pc valid for UC + datapath
//  instr       out  32  held instruction word
//  op          out  7   instr[6:0]
//  f3          out  3   instr[14:12]
//  f7          out  7   instr[31:25]
//  pc          out  32  address of held instruction
//  pcPlus4     out  32  pc + 4 (mod 2^32)
//  instrAck    in   1   datapath retires held instruction this cycle
//  pcSrc       in   1   from UC: 1 = take pcTarget, 0 = pc+4
//  pcTarget    in   32  branch/jump target from datapath
//  fetchFault  out  1   sticky: misaligned target, fetch halted
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=IDLE, imemReq=0, instrValid=0, instr=32'h0000_0013
//   (NOP), fetchFault=0; outstanding fetch forgotten (imem shares reset).
//  FSM: IDLE -> REQ (1 cycle after reset release).
//   REQ : imemReq=1, imemAddr=pc; gnt -> WAIT (gnt+rvalid same cycle -> HOLD).
//   WAIT: rvalid -> instr<=imemRData, instrValid=1 next cycle -> HOLD.
//   HOLD: outputs stable until instrAck. On ack: pc <= pcSrc ? pcTarget : pc+4,
//         instrValid=0 next cycle, -> REQ. pcSrc/pcTarget sampled only with ack.
//   FAULT: entered on ack with pcSrc=1 and pcTarget[1:0]!=0; fetchFault=1,
//         imemReq=0, instrValid=0, pc<=pcTarget; left only by reset.
//  Latency: ack -> next imemReq 1 cycle; 0-wait memory (gnt in REQ, rvalid next)
//   gives instrValid 2 cycles after imemReq rises; 1 instr per 3 cycles.
//  rvalid outside WAIT/REQ-granted is ignored. instrAck while !instrValid ignored.
//  pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000, no fault.
//  reset mid-WAIT/HOLD: same as reset; held instr dropped, next fetch at RESET_PC.
// CONFIGURATION
//  IFU_PREFETCH_EN defined: one-entry prefetch buffer. In HOLD, issue a fetch of
//   pc+4 in parallel; on ack with pcSrc=0 and buffer filled, instrValid is
//   re-asserted the next cycle without a new request (1 instr / 2 cycles
//   when buffered). Ack with pcSrc=1 discards buffer; an in-flight prefetch's
//   rvalid is dropped, then target fetched. Never more than 1 outstanding.
//  Undefined: no fetch issued in HOLD; behaviour exactly as in BEHAVIOUR.
// STRUCTURE
//  Package ifu_pkg: fsm state enum (IDLE,REQ,WAIT,HOLD,FAULT), NOP_INSTR
//   32'h0000_0013, field slice positions (OP_LSB, F3_LSB, F7_LSB).
//  Sub-module ifu_pc_next: combinational next-PC select + alignment check.
//  Prefetch buffer inline under `ifdef IFU_PREFETCH_EN.
// TESTING
//  1 reset, 0-wait imem returning 32'h0020_8133 @0 -> imemAddr=0, instrValid,
//    op=7'h33 f3=3'h0 f7=7'h00, pc=0, pcPlus4=4.
//  2 ack pcSrc=0 -> next imemAddr=4; ack pcSrc=1 pcTarget=32'h40 -> imemAddr=32'h40.
//  3 ack pcSrc=1 pcTarget=32'h42 -> fetchFault=1, imemReq=0 permanently until reset.
//  4 gnt delayed 3 cycles, rvalid 2 after gnt -> imemAddr stable, instrValid only
//    after rvalid, outputs held until ack.
//  5 reset asserted in WAIT -> next cycle imemReq=0, instrValid=0; pc=RESET_PC.
//  6 IFU_PREFETCH_EN: ack pcSrc=0 with buffer full -> instrValid 1 cycle later,
//    no extra imemReq; pcSrc=1 -> buffered word never presented.

Source files
------------

// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg
// Shared types and constants for the instruction fetch unit: the fetch FSM
// state encoding, the NOP word held after reset, and the bit positions of the
// opcode / funct3 / funct7 fields inside an RV32 instruction word.
// No ports (package).
// ---------------------------------------------------------------------------
package ifu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } ifu_state_e;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam int OP_LSB = 0;
  localparam int F3_LSB = 12;
  localparam int F7_LSB = 25;

endpackage

// File: rtl/ifu_pc_next.sv
// ---------------------------------------------------------------------------
// ifu_pc_next
// Combinational next-PC selection for the fetch unit, plus the alignment
// check on redirect targets.
// Ports:
//   pc_i          current PC
//   pcSrc_i       1 = take pcTarget_i, 0 = sequential
//   pcTarget_i    branch/jump target
//   pcPlus4_o     pc_i + 4, wrapping modulo 2^32
//   nextPc_o      selected next PC
//   misaligned_o  a redirect to a target that is not word aligned
// ---------------------------------------------------------------------------
module ifu_pc_next
  import ifu_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic            pcSrc_i,
  input  logic [XLEN-1:0] pcTarget_i,
  output logic [XLEN-1:0] pcPlus4_o,
  output logic [XLEN-1:0] nextPc_o,
  output logic            misaligned_o
);

  assign pcPlus4_o    = pc_i + 32'd4;
  assign nextPc_o     = pcSrc_i ? pcTarget_i : pcPlus4_o;
  // Only a taken redirect can misalign; sequential PCs stay word aligned.
  assign misaligned_o = pcSrc_i && (pcTarget_i[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Front end for the control unit: owns the PC, fetches 32-bit instructions
// over a req/gnt + rvalid handshake, holds the current instruction and splits
// it into op/f3/f7. On retire (instrAck) the next PC is pc+4 or pcTarget.
// A misaligned redirect target stops fetching until reset.
// Optional feature macro: IFU_PREFETCH_EN adds a one-entry prefetch buffer
// that fetches pc+4 while an instruction is held.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   imemReq/imemAddr      fetch request and address
//   imemGnt               request accepted
//   imemRValid/imemRData  read data return
//   instrValid            instr/op/f3/f7/pc valid
//   instr, op, f3, f7     held instruction and its fields
//   pc, pcPlus4           address of held instruction and pc+4
//   instrAck              held instruction retired this cycle
//   pcSrc, pcTarget       next-PC select and redirect target
//   fetchFault            sticky misaligned-target fault
// ---------------------------------------------------------------------------
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imemReq,
  output logic [XLEN-1:0] imemAddr,
  input  logic            imemGnt,
  input  logic            imemRValid,
  input  logic [XLEN-1:0] imemRData,
  output logic            instrValid,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      op,
  output logic [2:0]      f3,
  output logic [6:0]      f7,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcPlus4,
  input  logic            instrAck,
  input  logic            pcSrc,
  input  logic [XLEN-1:0] pcTarget,
  output logic            fetchFault
);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] nextPc;
  logic            misaligned;

  ifu_pc_next u_pc_next (
    .pc_i         (pc_q),
    .pcSrc_i      (pcSrc),
    .pcTarget_i   (pcTarget),
    .pcPlus4_o    (pcPlus4),
    .nextPc_o     (nextPc),
    .misaligned_o (misaligned)
  );

`ifdef IFU_PREFETCH_EN
  // Prefetch buffer: pfPend = granted fetch of pc+4 awaiting rvalid,
  // pfValid = buffered word present, drop = a discarded prefetch is still
  // in flight and its rvalid must be swallowed before fetching the target.
  logic            pfPend_q, pfPend_d;
  logic            pfValid_q, pfValid_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] pfData_q, pfData_d;
  logic            pfIssue, pfGnt;

  assign pfIssue = (state_q == HOLD) && !pfPend_q && !pfValid_q;
  assign pfGnt   = pfIssue && imemGnt;

  always_comb begin
    pfPend_d  = pfPend_q;
    pfValid_d = pfValid_q;
    pfData_d  = pfData_q;
    drop_d    = drop_q;
    if (drop_q && imemRValid) drop_d = 1'b0;
    if (state_q == HOLD) begin
      if (pfGnt) begin
        if (imemRValid) begin
          pfValid_d = 1'b1;
          pfData_d  = imemRData;
        end else begin
          pfPend_d = 1'b1;
        end
      end else if (pfPend_q && imemRValid) begin
        pfValid_d = 1'b1;
        pfData_d  = imemRData;
        pfPend_d  = 1'b0;
      end
      // A redirect throws the sequential prefetch away.
      if (instrAck && pcSrc) begin
        pfValid_d = 1'b0;
        pfPend_d  = 1'b0;
        drop_d    = (pfPend_q || pfGnt) && !imemRValid;
      end
    end
    if (state_q == WAIT) begin
      if (pfValid_q) pfValid_d = 1'b0;
      else if (pfPend_q && imemRValid) pfPend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pfPend_q  <= 1'b0;
      pfValid_q <= 1'b0;
      drop_q    <= 1'b0;
      pfData_q  <= '0;
    end else begin
      pfPend_q  <= pfPend_d;
      pfValid_q <= pfValid_d;
      drop_q    <= drop_d;
      pfData_q  <= pfData_d;
    end
  end
`endif

  // State, PC and held instruction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Next-state logic: pcSrc/pcTarget only matter in the retire cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imemReq && imemGnt) begin
          if (imemRValid) begin
            instr_d = imemRData;
            state_d = HOLD;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
`ifdef IFU_PREFETCH_EN
        if (pfValid_q) begin
          instr_d = pfData_q;
          state_d = HOLD;
        end else
`endif
        if (imemRValid) begin
          instr_d = imemRData;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (instrAck) begin
          pc_d = nextPc;
          if (misaligned) state_d = FAULT;
`ifdef IFU_PREFETCH_EN
          else if (!pcSrc && (pfValid_q || pfPend_q || pfGnt)) state_d = WAIT;
`endif
          else state_d = REQ;
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    imemReq  = 1'b0;
    imemAddr = pc_q;
    unique case (state_q)
`ifdef IFU_PREFETCH_EN
      REQ: imemReq = !drop_q;
      HOLD: begin
        imemReq  = pfIssue;
        imemAddr = pcPlus4;
      end
`else
      REQ: imemReq = 1'b1;
`endif
      default: imemReq = 1'b0;
    endcase
    instrValid = (state_q == HOLD);
    fetchFault = (state_q == FAULT);
  end

  assign instr = instr_q;
  assign pc    = pc_q;
  assign op    = instr_q[OP_LSB +: 7];
  assign f3    = instr_q[F3_LSB +: 3];
  assign f7    = instr_q[F7_LSB +: 7];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed self-checking bench for instr_fetch_unit. The instruction memory
// is driven by hand inside each scenario task; expected values are
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt = 1'b0;
  logic        imemRValid = 1'b0;
  logic [31:0] imemRData = '0;
  logic        instrValid;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        instrAck = 1'b0;
  logic        pcSrc = 1'b0;
  logic [31:0] pcTarget = '0;
  logic        fetchFault;

  int compared = 0;
  int mismatched = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemGnt(imemGnt),
    .imemRValid(imemRValid), .imemRData(imemRData),
    .instrValid(instrValid), .instr(instr), .op(op), .f3(f3), .f7(f7),
    .pc(pc), .pcPlus4(pcPlus4),
    .instrAck(instrAck), .pcSrc(pcSrc), .pcTarget(pcTarget),
    .fetchFault(fetchFault)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait fetch from REQ: gnt now, rvalid on the following cycle.
  task automatic applyStimulus(input logic [31:0] data);
    imemGnt = 1'b1;
    tick();
    imemGnt = 1'b0;
    imemRValid = 1'b1;
    imemRData = data;
    tick();
    imemRValid = 1'b0;
  endtask

  task automatic retire(input logic src, input logic [31:0] tgt);
    instrAck = 1'b1;
    pcSrc = src;
    pcTarget = tgt;
    tick();
    instrAck = 1'b0;
    pcSrc = 1'b0;
    pcTarget = 32'hDEAD_BEEF;
  endtask

  task automatic resetToReq();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    compared++; if (imemReq !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_req got %b exp 0", imemReq); end
    compared++; if (instrValid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_valid got %b exp 0", instrValid); end
    compared++; if (instr !== 32'h0000_0013) begin mismatched++; $display("[TB] FAIL rst_instr got %h exp 00000013", instr); end
    compared++; if (pc !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_pc got %h exp 0", pc); end
    compared++; if (fetchFault !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_fault got %b exp 0", fetchFault); end
    reset = 1'b0;
    tick();
    compared++; if (imemReq !== 1'b1) begin mismatched++; $display("[TB] FAIL first_req got %b exp 1", imemReq); end
    compared++; if (imemAddr !== 32'h0) begin mismatched++; $display("[TB] FAIL first_addr got %h exp 0", imemAddr); end
  endtask

  task automatic test_basic_fetch();
    imemGnt = 1'b1;
    tick();
    imemGnt = 1'b0;
    compared++; if (imemReq !== 1'b0) begin mismatched++; $display("[TB] FAIL wait_req got %b exp 0", imemReq); end
    compared++; if (instrValid !== 1'b0) begin mismatched++; $display("[TB] FAIL wait_valid got %b exp 0", instrValid); end
    imemRValid = 1'b1;
    imemRData = 32'h0020_8133;
    tick();
    imemRValid = 1'b0;
    compared++; if (instrValid !== 1'b1) begin mismatched++; $display("[TB] FAIL hold_valid got %b exp 1", instrValid); end
    compared++; if (instr !== 32'h0020_8133) begin mismatched++; $display("[TB] FAIL hold_instr got %h exp 00208133", instr); end
    compared++; if (op !== 7'h33) begin mismatched++; $display("[TB] FAIL op got %h exp 33", op); end
    compared++; if (f3 !== 3'h0) begin mismatched++; $display("[TB] FAIL f3 got %h exp 0", f3); end
    compared++; if (f7 !== 7'h00) begin mismatched++; $display("[TB] FAIL f7 got %h exp 00", f7); end
    compared++; if (pc !== 32'h0) begin mismatched++; $display("[TB] FAIL pc got %h exp 0", pc); end
    compared++; if (pcPlus4 !== 32'h4) begin mismatched++; $display("[TB] FAIL pcPlus4 got %h exp 4", pcPlus4); end
  endtask

  task automatic test_pc_select();
    retire(1'b0, 32'h0000_0080);
    compared++; if (imemAddr !== 32'h4) begin mismatched++; $display("[TB] FAIL seq_addr got %h exp 4", imemAddr); end
    compared++; if (imemReq !== 1'b1) begin mismatched++; $display("[TB] FAIL seq_req got %b exp 1", imemReq); end
    compared++; if (instrValid !== 1'b0) begin mismatched++; $display("[TB] FAIL seq_valid got %b exp 0", instrValid); end
    applyStimulus(32'h4020_81B3);
    compared++; if (f7 !== 7'h20) begin mismatched++; $display("[TB] FAIL sub_f7 got %h exp 20", f7); end
    compared++; if (pcPlus4 !== 32'h8) begin mismatched++; $display("[TB] FAIL sub_pc4 got %h exp 8", pcPlus4); end
    retire(1'b1, 32'h0000_0040);
    compared++; if (imemAddr !== 32'h40) begin mismatched++; $display("[TB] FAIL br_addr got %h exp 40", imemAddr); end
    // Ack while nothing is held must be ignored.
    retire(1'b1, 32'h0000_0080);
    compared++; if (imemAddr !== 32'h40) begin mismatched++; $display("[TB] FAIL idle_ack_addr got %h exp 40", imemAddr); end
    applyStimulus(32'h0000_7033);
    compared++; if (f3 !== 3'h7) begin mismatched++; $display("[TB] FAIL f3_7 got %h exp 7", f3); end
    compared++; if (pc !== 32'h40) begin mismatched++; $display("[TB] FAIL br_pc got %h exp 40", pc); end
  endtask

  task automatic test_fault();
    retire(1'b1, 32'h0000_0042);
    compared++; if (fetchFault !== 1'b1) begin mismatched++; $display("[TB] FAIL fault_set got %b exp 1", fetchFault); end
    compared++; if (imemReq !== 1'b0) begin mismatched++; $display("[TB] FAIL fault_req got %b exp 0", imemReq); end
    compared++; if (instrValid !== 1'b0) begin mismatched++; $display("[TB] FAIL fault_valid got %b exp 0", instrValid); end
    compared++; if (pc !== 32'h42) begin mismatched++; $display("[TB] FAIL fault_pc got %h exp 42", pc); end
    imemGnt = 1'b1;
    imemRValid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    imemGnt = 1'b0;
    imemRValid = 1'b0;
    compared++; if (imemReq !== 1'b0 || fetchFault !== 1'b1) begin mismatched++; $display("[TB] FAIL fault_sticky got req=%b fault=%b exp req=0 fault=1", imemReq, fetchFault); end
  endtask

  task automatic test_wrap();
    resetToReq();
    applyStimulus(32'h0000_0013);
    retire(1'b1, 32'hFFFF_FFFC);
    compared++; if (imemAddr !== 32'hFFFF_FFFC) begin mismatched++; $display("[TB] FAIL top_addr got %h exp fffffffc", imemAddr); end
    applyStimulus(32'h0000_0013);
    compared++; if (pcPlus4 !== 32'h0) begin mismatched++; $display("[TB] FAIL wrap_pc4 got %h exp 0", pcPlus4); end
    retire(1'b0, 32'h0);
    compared++; if (imemAddr !== 32'h0 || fetchFault !== 1'b0) begin mismatched++; $display("[TB] FAIL wrap_addr got %h fault=%b exp 0 fault=0", imemAddr, fetchFault); end
  endtask

  task automatic test_slow_mem();
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin mismatched++; $display("[TB] FAIL stall_req got req=%b addr=%h exp req=1 addr=0", imemReq, imemAddr); end
    end
    imemGnt = 1'b1;
    tick();
    imemGnt = 1'b0;
    tick();
    compared++; if (instrValid !== 1'b0) begin mismatched++; $display("[TB] FAIL slow_valid_early got %b exp 0", instrValid); end
    imemRValid = 1'b1;
    imemRData = 32'h00A5_0513;
    tick();
    imemRValid = 1'b0;
    compared++; if (instrValid !== 1'b1 || instr !== 32'h00A5_0513) begin mismatched++; $display("[TB] FAIL slow_data got v=%b %h exp v=1 00a50513", instrValid, instr); end
    imemRValid = 1'b1;
    imemRData = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) tick();
    imemRValid = 1'b0;
    compared++; if (instrValid !== 1'b1 || instr !== 32'h00A5_0513) begin mismatched++; $display("[TB] FAIL slow_hold got v=%b %h exp v=1 00a50513", instrValid, instr); end
    retire(1'b0, 32'h0);
    compared++; if (imemAddr !== 32'h4) begin mismatched++; $display("[TB] FAIL slow_next got %h exp 4", imemAddr); end
  endtask

  task automatic test_reset_in_wait();
    imemGnt = 1'b1;
    tick();
    imemGnt = 1'b0;
    reset = 1'b1;
    tick();
    compared++; if (imemReq !== 1'b0 || instrValid !== 1'b0) begin mismatched++; $display("[TB] FAIL rw_out got req=%b v=%b exp 0 0", imemReq, instrValid); end
    compared++; if (pc !== 32'h0) begin mismatched++; $display("[TB] FAIL rw_pc got %h exp 0", pc); end
    reset = 1'b0;
    tick();
    compared++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin mismatched++; $display("[TB] FAIL rw_refetch got req=%b addr=%h exp 1 0", imemReq, imemAddr); end
  endtask

`ifdef IFU_PREFETCH_EN
  task automatic test_back_to_back();
    applyStimulus(32'h0010_0093);
    compared++; if (imemReq !== 1'b1 || imemAddr !== 32'h4) begin mismatched++; $display("[TB] FAIL pf_issue got req=%b addr=%h exp 1 4", imemReq, imemAddr); end
    applyStimulus(32'h0020_0113);
    compared++; if (imemReq !== 1'b0) begin mismatched++; $display("[TB] FAIL pf_single got %b exp 0", imemReq); end
    retire(1'b0, 32'h0);
    compared++; if (instrValid !== 1'b0 || imemReq !== 1'b0) begin mismatched++; $display("[TB] FAIL pf_gap got v=%b req=%b exp 0 0", instrValid, imemReq); end
    tick();
    compared++; if (instrValid !== 1'b1 || instr !== 32'h0020_0113 || pc !== 32'h4) begin mismatched++; $display("[TB] FAIL pf_use got v=%b %h pc=%h exp 1 00200113 4", instrValid, instr, pc); end
    applyStimulus(32'h0030_0193);
    retire(1'b1, 32'h0000_0100);
    compared++; if (imemReq !== 1'b1 || imemAddr !== 32'h100) begin mismatched++; $display("[TB] FAIL pf_redirect got req=%b addr=%h exp 1 100", imemReq, imemAddr); end
    applyStimulus(32'h0040_0213);
    compared++; if (instr !== 32'h0040_0213 || pc !== 32'h100) begin mismatched++; $display("[TB] FAIL pf_discard got %h pc=%h exp 00400213 100", instr, pc); end
  endtask
`endif

  initial begin
    pcTarget = 32'hDEAD_BEEF;
    test_reset();
    test_basic_fetch();
    test_pc_select();
    test_fault();
    test_wrap();
    test_slow_mem();
    test_reset_in_wait();
`ifdef IFU_PREFETCH_EN
    test_back_to_back();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
